// File: rtl/watch_set_core.sv
// watch_set_core: time-of-day counter (msec/sec/min/hour) with a RUN/SET editing mode.
// Latency: all outputs are registered; tick, carry chain and button/mode edits appear one cycle after the sampling edge.
// Backpressure: none; i_btn/i_mode are one-cycle pulses, and a pulse held N cycles acts N times.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   i_btn[3:0] debounced pulses: [0]=L, [1]=R, [2]=U, [3]=D
//   i_mode     pulse that toggles between RUN and SET
//   msec/sec/min/hour  time-of-day outputs
//   o_pm       PM flag (12-hour build only; tied 0 otherwise)
//   o_editing  high in any SET state
//   o_field    field being edited: 0 sec, 1 min, 2 hour
//
// Optional feature macro: WATCH_12H_EN switches the hour output to 1..12 and drives o_pm.
// The internal hour counter always runs 0..23.

module watch_set_core #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int TICK_HZ   = 100,
    parameter int INIT_HOUR = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i_btn,
    input  logic       i_mode,
    output logic [6:0] msec,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hour,
    output logic       o_pm,
    output logic       o_editing,
    output logic [1:0] o_field
);

    // Prescaler geometry
    localparam int              DIV       = CLK_FREQ / TICK_HZ;
    localparam int              PW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   PRE_LAST  = PW'(DIV - 1);
    localparam logic [6:0]      MSEC_LAST = 7'(TICK_HZ - 1);
    localparam logic [4:0]      INIT_H    = 5'(INIT_HOUR);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_SEC  = 2'd1,
        ST_SET_MIN  = 2'd2,
        ST_SET_HOUR = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [PW-1:0] presc_q, presc_d;
    logic [6:0]    msec_q,  msec_d;
    logic [5:0]    sec_q,   sec_d;
    logic [5:0]    min_q,   min_d;
    logic [4:0]    hour_q,  hour_d;

    logic editing_c;
    logic [1:0] field_c;

    // Button decode. Opposing buttons pressed together cancel each other.
    logic btn_l, btn_r, btn_u, btn_d;
    logic sel_l, sel_r, adj_up, adj_dn;
    logic tick;

    assign btn_l  = i_btn[0];
    assign btn_r  = i_btn[1];
    assign btn_u  = i_btn[2];
    assign btn_d  = i_btn[3];
    assign sel_l  = btn_l & ~btn_r;
    assign sel_r  = btn_r & ~btn_l;
    assign adj_up = btn_u & ~btn_d;
    assign adj_dn = btn_d & ~btn_u;

    // A mode pulse in RUN clears the prescaler before it can terminate,
    // so entering SET never produces a tick.
    assign tick = (state_q == ST_RUN) && !i_mode && (presc_q == PRE_LAST);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic. i_mode wins over any selection move.
    // L walks toward more significant fields, R the other way.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (i_mode) state_d = ST_SET_SEC;
            end
            ST_SET_SEC: begin
                if (i_mode)     state_d = ST_RUN;
                else if (sel_l) state_d = ST_SET_MIN;
                else if (sel_r) state_d = ST_SET_HOUR;
            end
            ST_SET_MIN: begin
                if (i_mode)     state_d = ST_RUN;
                else if (sel_l) state_d = ST_SET_HOUR;
                else if (sel_r) state_d = ST_SET_SEC;
            end
            ST_SET_HOUR: begin
                if (i_mode)     state_d = ST_RUN;
                else if (sel_l) state_d = ST_SET_SEC;
                else if (sel_r) state_d = ST_SET_MIN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode from the state register only
    // ------------------------------------------------------------------
    always_comb begin
        editing_c = 1'b0;
        field_c   = 2'd0;
        case (state_q)
            ST_SET_SEC:  begin editing_c = 1'b1; field_c = 2'd0; end
            ST_SET_MIN:  begin editing_c = 1'b1; field_c = 2'd1; end
            ST_SET_HOUR: begin editing_c = 1'b1; field_c = 2'd2; end
            default:     begin editing_c = 1'b0; field_c = 2'd0; end
        endcase
    end

    assign o_editing = editing_c;
    assign o_field   = field_c;

    // ------------------------------------------------------------------
    // Datapath next-state: prescaler, carry chain and SET adjustments
    // ------------------------------------------------------------------
    always_comb begin
        presc_d = presc_q;
        msec_d  = msec_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;

        if (state_q == ST_RUN) begin
            if (i_mode) begin
                // Entering SET: freeze at a clean sub-second boundary.
                presc_d = '0;
                msec_d  = '0;
            end else if (tick) begin
                presc_d = '0;
                // Whole carry chain resolves on the tick edge.
                if (msec_q == MSEC_LAST) begin
                    msec_d = '0;
                    if (sec_q == 6'd59) begin
                        sec_d = '0;
                        if (min_q == 6'd59) begin
                            min_d  = '0;
                            hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                        end else begin
                            min_d = min_q + 6'd1;
                        end
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end else begin
                    msec_d = msec_q + 7'd1;
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end else begin
            // SET: counting frozen; prescaler held at 0 so the first tick
            // after leaving SET lands exactly one tick period later.
            presc_d = '0;
            msec_d  = '0;
            // Adjustments use the field selected before any same-edge move;
            // a mode pulse discards them. No carry/borrow between fields.
            if (!i_mode) begin
                case (state_q)
                    ST_SET_SEC: begin
                        if (adj_up)      sec_d = (sec_q == 6'd59) ? 6'd0  : sec_q + 6'd1;
                        else if (adj_dn) sec_d = (sec_q == 6'd0)  ? 6'd59 : sec_q - 6'd1;
                    end
                    ST_SET_MIN: begin
                        if (adj_up)      min_d = (min_q == 6'd59) ? 6'd0  : min_q + 6'd1;
                        else if (adj_dn) min_d = (min_q == 6'd0)  ? 6'd59 : min_q - 6'd1;
                    end
                    ST_SET_HOUR: begin
                        if (adj_up)      hour_d = (hour_q == 5'd23) ? 5'd0  : hour_q + 5'd1;
                        else if (adj_dn) hour_d = (hour_q == 5'd0)  ? 5'd23 : hour_q - 5'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            msec_q  <= '0;
            sec_q   <= '0;
            min_q   <= '0;
            hour_q  <= INIT_H;
        end else begin
            presc_q <= presc_d;
            msec_q  <= msec_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
        end
    end

    assign msec = msec_q;
    assign sec  = sec_q;
    assign min  = min_q;

`ifdef WATCH_12H_EN
    // 12-hour view: 0 and 12 both display as 12; PM is the upper half-day.
    // Registered from hour_d so the display stays in step with the counter.
    function automatic logic [4:0] to_12h(input logic [4:0] h);
        if (h == 5'd0)       return 5'd12;
        else if (h > 5'd12)  return h - 5'd12;
        else                 return h;
    endfunction

    logic [4:0] hour_disp_q;
    logic       pm_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hour_disp_q <= to_12h(INIT_H);
            pm_q        <= (INIT_H >= 5'd12);
        end else begin
            hour_disp_q <= to_12h(hour_d);
            pm_q        <= (hour_d >= 5'd12);
        end
    end

    assign hour = hour_disp_q;
    assign o_pm = pm_q;
`else
    assign hour = hour_q;
    assign o_pm = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Range invariants
    // ------------------------------------------------------------------
    a_field_legal: assert property (@(posedge clk) disable iff (rst) o_field != 2'd3);
    a_sec_range:   assert property (@(posedge clk) disable iff (rst) sec_q < 6'd60);
    a_min_range:   assert property (@(posedge clk) disable iff (rst) min_q < 6'd60);
    a_hour_range:  assert property (@(posedge clk) disable iff (rst) hour_q < 5'd24);
    a_msec_range:  assert property (@(posedge clk) disable iff (rst) msec_q <= MSEC_LAST);
    a_set_frozen:  assert property (@(posedge clk) disable iff (rst)
                                    (state_q != ST_RUN) |-> (msec_q == 7'd0 && presc_q == '0));

endmodule

// File: tb/tb_watch_set_core.sv
// tb_watch_set_core: directed-vector bench for watch_set_core at CLK_FREQ=1000, TICK_HZ=100 (10-cycle tick).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at that same point.
// A 12-hour section is compiled in when WATCH_12H_EN is defined.

module tb_watch_set_core;

    localparam logic [3:0] B_L = 4'b0001;
    localparam logic [3:0] B_R = 4'b0010;
    localparam logic [3:0] B_U = 4'b0100;
    localparam logic [3:0] B_D = 4'b1000;

    logic       clk;
    logic       rst;
    logic [3:0] i_btn;
    logic       i_mode;
    logic [6:0] msec;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic       o_pm;
    logic       o_editing;
    logic [1:0] o_field;

    int n_tests = 0;
    int n_fail  = 0;

    watch_set_core #(
        .CLK_FREQ (1000),
        .TICK_HZ  (100),
        .INIT_HOUR(12)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_btn    (i_btn),
        .i_mode   (i_mode),
        .msec     (msec),
        .sec      (sec),
        .min      (min),
        .hour     (hour),
        .o_pm     (o_pm),
        .o_editing(o_editing),
        .o_field  (o_field)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected display hour / PM flag for a 0..23 internal hour.
    function automatic int exp_hour(input int h);
`ifdef WATCH_12H_EN
        return (h % 12 == 0) ? 12 : h % 12;
`else
        return h;
`endif
    endfunction

    function automatic int exp_pm(input int h);
`ifdef WATCH_12H_EN
        return (h >= 12) ? 1 : 0;
`else
        return (h < 0) ? 1 : 0;
`endif
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [3:0] b, input logic m);
        i_btn  = b;
        i_mode = m;
        step(1);
        i_btn  = 4'b0;
        i_mode = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s, input int ms);
        check({tag, ".hour"}, int'(hour), exp_hour(h));
        check({tag, ".min"},  int'(min),  m);
        check({tag, ".sec"},  int'(sec),  s);
        check({tag, ".msec"}, int'(msec), ms);
        check({tag, ".pm"},   int'(o_pm), exp_pm(h));
    endtask

    initial begin
        rst    = 1'b1;
        i_btn  = 4'b0;
        i_mode = 1'b0;

        // ---- Reset state and free-running count ----
        do_reset();
        check_time("rst", 12, 0, 0, 0);
        check("rst.editing", int'(o_editing), 0);
        check("rst.field",   int'(o_field),   0);
        step(9);
        check("tick9.msec", int'(msec), 0);
        step(1);
        check("tick10.msec", int'(msec), 1);
        step(990);
        check_time("run1000", 12, 0, 1, 0);
        pulse(B_U, 1'b0);
        check("run_btn_ignored.sec", int'(sec), 1);
        check("run_btn_ignored.editing", int'(o_editing), 0);

        // ---- Preload 23:59:59 and roll over midnight ----
        do_reset();
        pulse(4'b0, 1'b1);
        check("set.editing", int'(o_editing), 1);
        check("set.field0",  int'(o_field),   0);
        pulse(B_L, 1'b0);
        pulse(B_L, 1'b0);
        check("sel_hour.field", int'(o_field), 2);
        repeat (13) pulse(B_D, 1'b0);
        check("hour_dn13", int'(hour), exp_hour(23));
        pulse(B_R, 1'b0);
        check("r_to_min.field", int'(o_field), 1);
        pulse(B_D, 1'b0);
        check("min_wrap_dn", int'(min), 59);
        pulse(B_R, 1'b0);
        check("r_to_sec.field", int'(o_field), 0);
        pulse(B_D, 1'b0);
        check("sec_wrap_dn", int'(sec), 59);
        pulse(4'b0, 1'b1);
        check("exit.editing", int'(o_editing), 0);
        step(990);
        check_time("pre_midnight", 23, 59, 59, 99);
        step(10);
        check_time("midnight", 0, 0, 0, 0);

        // ---- Field stepping and frozen counting ----
        do_reset();
        pulse(4'b0, 1'b1);
        repeat (61) pulse(B_U, 1'b0);
        check("u61.sec",   int'(sec),     1);
        check("u61.min",   int'(min),     0);
        check("u61.field", int'(o_field), 0);
        step(25);
        check("frozen.msec", int'(msec), 0);
        check("frozen.sec",  int'(sec),  1);
        pulse(B_L, 1'b0);
        pulse(B_D, 1'b0);
        check("l_d.min",   int'(min),     59);
        check("l_d.field", int'(o_field), 1);
        pulse(B_L, 1'b0);
        check("l2.field", int'(o_field), 2);

        // ---- Simultaneous events ----
        pulse(B_U | B_D, 1'b0);
        check("ud.hour", int'(hour), exp_hour(12));
        pulse(B_L | B_R, 1'b0);
        check("lr.field", int'(o_field), 2);
        pulse(B_L | B_U, 1'b0);
        check("lu.hour",  int'(hour),    exp_hour(13));
        check("lu.field", int'(o_field), 0);
        check("lu.sec",   int'(sec),     1);
        pulse(B_R, 1'b0);
        check("r_wrap.field", int'(o_field), 2);
        pulse(B_D, 1'b0);
        check("hour_dn.hour", int'(hour), exp_hour(12));
        pulse(B_U, 1'b1);
        check("mode_u.editing", int'(o_editing), 0);
        check("mode_u.hour",    int'(hour),      exp_hour(12));
        check("mode_u.sec",     int'(sec),       1);
        check("mode_u.min",     int'(min),       59);
        step(9);
        check("exit_tick9.msec", int'(msec), 0);
        step(1);
        check("exit_tick10.msec", int'(msec), 1);

        // ---- Reset while editing the hour ----
        pulse(4'b0, 1'b1);
        check("reenter.msec", int'(msec), 0);
        pulse(B_L, 1'b0);
        pulse(B_L, 1'b0);
        repeat (7) pulse(B_D, 1'b0);
        check("hour5", int'(hour), exp_hour(5));
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_time("rst_in_set", 12, 0, 0, 0);
        check("rst_in_set.editing", int'(o_editing), 0);
        check("rst_in_set.field",   int'(o_field),   0);

`ifdef WATCH_12H_EN
        // ---- 12-hour display ----
        pulse(4'b0, 1'b1);
        pulse(B_L, 1'b0);
        pulse(B_L, 1'b0);
        pulse(B_D, 1'b0);
        check("h12_11.hour", int'(hour), 11);
        check("h12_11.pm",   int'(o_pm), 0);
        pulse(B_U, 1'b0);
        check("h12_12.hour", int'(hour), 12);
        check("h12_12.pm",   int'(o_pm), 1);
        pulse(B_U, 1'b0);
        check("h12_13.hour", int'(hour), 1);
        check("h12_13.pm",   int'(o_pm), 1);
        repeat (13) pulse(B_D, 1'b0);
        check("h12_0.hour", int'(hour), 12);
        check("h12_0.pm",   int'(o_pm), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
